// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module   : seq_det_pkg
// Purpose  : Shared constants and helpers for the serial pattern detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

  localparam int         MIN_PAT_LEN   = 2;
  localparam int         MAX_PAT_LEN   = 32;
  localparam logic [4:0] DEF_PAT_10011 = 5'b10011;

  function automatic bit pat_len_ok(input int len);
    return (len >= MIN_PAT_LEN) && (len <= MAX_PAT_LEN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_detector_param_if.sv
// ============================================================================
// Module   : seq_detector_param_if
// Purpose  : Serial bit/pattern-load/match-report bundle for the detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 5,
  parameter int CNT_W   = 8
);

  logic               din;
  logic               din_valid;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               count_clr;
  logic               seq_detected;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output din, din_valid, pat_load, pat_in, count_clr,
    input  seq_detected, match_count
  );

  modport slave (
    input  din, din_valid, pat_load, pat_in, count_clr,
    output seq_detected, match_count
  );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous clear (clear wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         inc,
  input  wire logic         clr,
  output logic [W-1:0]      count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Parametrised Moore serial pattern detector with reloadable
//            pattern, overlap mode and saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PAT_10011),
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  seq_detector_param_if.slave  bus
);

  localparam int                c_fill_w    = $clog2(PAT_LEN + 1);
  localparam logic [c_fill_w-1:0] c_fill_full = c_fill_w'(PAT_LEN);
  localparam logic [c_fill_w-1:0] c_fill_min  = c_fill_w'(PAT_LEN - 1);

  if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
    $error("seq_detector_param: PAT_LEN out of range");
  end

  // The oldest history bit is shifted out before every compare, so only
  // the youngest PAT_LEN-1 bits ever need to be stored.
  logic [PAT_LEN-2:0]  r_hist;
  logic [c_fill_w-1:0] r_fill;
  logic [PAT_LEN-1:0]  r_pat;
  logic                r_hit;

  logic [PAT_LEN-1:0]  w_next_hist;
  logic [c_fill_w-1:0] w_fill_inc;
  logic                w_match;
  logic [PAT_LEN-2:0]  w_hist_nxt;
  logic [c_fill_w-1:0] w_fill_nxt;
  logic [CNT_W-1:0]    w_count;

  assign w_next_hist = {r_hist, bus.din};
  assign w_fill_inc  = (r_fill == c_fill_full) ? r_fill : r_fill + 1'b1;
  assign w_match     = bus.din_valid && !bus.pat_load &&
                       (r_fill >= c_fill_min) && (w_next_hist == r_pat);

  if (OVERLAP) begin : g_overlap
    assign w_hist_nxt = w_next_hist[PAT_LEN-2:0];
    assign w_fill_nxt = w_fill_inc;
  end else begin : g_no_overlap
    assign w_hist_nxt = w_match ? '0 : w_next_hist[PAT_LEN-2:0];
    assign w_fill_nxt = w_match ? '0 : w_fill_inc;
  end

  // A load restarts detection and drops any bit offered in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= PATTERN;
      r_hit  <= 1'b0;
    end else if (bus.pat_load) begin
      r_pat  <= bus.pat_in;
      r_hist <= '0;
      r_fill <= '0;
      r_hit  <= 1'b0;
    end else if (bus.din_valid) begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_hit  <= w_match;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_match),
    .clr   (bus.count_clr),
    .count (w_count)
  );

  assign bus.seq_detected = r_hit;
  assign bus.match_count  = w_count;

endmodule

`default_nettype wire
